// File: rtl/regfile_sb.sv
// regfile_sb: 2-read / 2-write register file with a per-register busy scoreboard.
// Reads and busy lookups are combinational from stored state. busy_cnt is a
// registered population count of the busy bits.
// Optional feature macro: REGFILE_BYPASS_EN forwards same-cycle write data and
// write-clears onto the read ports. When it is undefined, no forwarding logic
// is built.
module regfile_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic              rbusy1,
    output logic              rbusy2,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] waddr0,
    input  logic [ADDR_W-1:0] waddr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              sb_set,
    input  logic [ADDR_W-1:0] sb_addr,
    output logic [ADDR_W:0]   busy_cnt
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic wr0_ok, wr1_ok, set_ok;

    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rdata [2];
    logic              rbusy [2];

    // Qualified write/set strobes: dropped in reset cycles and on hardwired r0
    always_comb begin
        wr0_ok = we0    && !reset && !(ZERO_REG && (waddr0  == '0));
        wr1_ok = we1    && !reset && !(ZERO_REG && (waddr1  == '0));
        set_ok = sb_set && !reset && !(ZERO_REG && (sb_addr == '0));
    end

    // Next busy vector: writes clear, then set overrides; count follows the vector
    always_comb begin
        busy_d = busy_q;
        cnt_d  = '0;
        if (wr0_ok) busy_d[waddr0]  = 1'b0;
        if (wr1_ok) busy_d[waddr1]  = 1'b0;
        if (set_ok) busy_d[sb_addr] = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + CNT_W'(busy_d[i]);
        end
    end

    // Register array, scoreboard and count state; port 1 written last so it wins
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr0_ok) rf_q[waddr0] <= wdata0;
            if (wr1_ok) rf_q[waddr1] <= wdata1;
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign raddr[0] = raddr1;
    assign raddr[1] = raddr2;

    // Read ports: stored data/busy, r0 forced to zero, optional same-cycle forwarding
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            if (ZERO_REG && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rbusy[p] = 1'b0;
            end else begin
                rdata[p] = rf_q[raddr[p]];
                rbusy[p] = busy_q[raddr[p]];
`ifdef REGFILE_BYPASS_EN
                if (wr1_ok && (waddr1 == raddr[p])) begin
                    rdata[p] = wdata1;
                end else if (wr0_ok && (waddr0 == raddr[p])) begin
                    rdata[p] = wdata0;
                end
                if (((wr0_ok && (waddr0 == raddr[p])) || (wr1_ok && (waddr1 == raddr[p])))
                    && !(set_ok && (sb_addr == raddr[p]))) begin
                    rbusy[p] = 1'b0;
                end
`endif
            end
        end
    end

    assign rdata1   = rdata[0];
    assign rdata2   = rdata[1];
    assign rbusy1   = rbusy[0];
    assign rbusy2   = rbusy[1];
    assign busy_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed scoreboard bench for regfile_sb (default parameters).
module tb_regfile_sb;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic [ADDR_W-1:0] raddr1, raddr2;
    logic [DATA_W-1:0] rdata1, rdata2;
    logic              rbusy1, rbusy2;
    logic              we0, we1;
    logic [ADDR_W-1:0] waddr0, waddr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              sb_set;
    logic [ADDR_W-1:0] sb_addr;
    logic [ADDR_W:0]   busy_cnt;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q [$];
    int   n_assert = 0;
    int   n_fail   = 0;

    regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_REG(1'b1)) dut (
        .clk      (clk),
        .reset    (reset),
        .raddr1   (raddr1),
        .raddr2   (raddr2),
        .rdata1   (rdata1),
        .rdata2   (rdata2),
        .rbusy1   (rbusy1),
        .rbusy2   (rbusy2),
        .we0      (we0),
        .we1      (we1),
        .waddr0   (waddr0),
        .waddr1   (waddr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .sb_set   (sb_set),
        .sb_addr  (sb_addr),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_assert++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $error("FAIL sb_empty observed=%h expected=<queued value>", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        we0 = 1'b0; we1 = 1'b0; sb_set = 1'b0;
    endtask

    initial begin
        reset = 1'b1; raddr1 = '0; raddr2 = '0;
        we0 = 1'b0; we1 = 1'b0; waddr0 = '0; waddr1 = '0;
        wdata0 = '0; wdata1 = '0; sb_set = 1'b0; sb_addr = '0;
        tick(); tick();
        reset = 1'b0;

        // Post-reset state
        raddr1 = 5'd5; raddr2 = 5'd7; #1;
        push("rst_rdata1", 32'h0); push("rst_rdata2", 32'h0);
        push("rst_rbusy1", 32'h0); push("rst_rbusy2", 32'h0);
        push("rst_cnt", 32'h0);
        check(rdata1); check(rdata2); check(32'(rbusy1)); check(32'(rbusy2)); check(32'(busy_cnt));

        // Port 0 write, visible next cycle
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'hDEADBEEF;
        push("wr_r5", 32'hDEADBEEF);
        tick(); idle(); raddr1 = 5'd5; #1;
        check(rdata1);

        // Same-address dual write: port 1 wins
        we0 = 1'b1; waddr0 = 5'd7; wdata0 = 32'h11111111;
        we1 = 1'b1; waddr1 = 5'd7; wdata1 = 32'h22222222;
        push("dual_wr_r7", 32'h22222222);
        tick(); idle(); raddr2 = 5'd7; #1;
        check(rdata2);

        // Hardwired r0 ignores write and set
        we0 = 1'b1; waddr0 = 5'd0; wdata0 = 32'hFFFFFFFF; sb_set = 1'b1; sb_addr = 5'd0;
        push("r0_rdata", 32'h0); push("r0_rbusy", 32'h0); push("r0_cnt", 32'h0);
        tick(); idle(); raddr1 = 5'd0; #1;
        check(rdata1); check(32'(rbusy1)); check(32'(busy_cnt));

        // Scoreboard set / clear / collision
        sb_set = 1'b1; sb_addr = 5'd3; push("set_r3_cnt", 32'd1);
        tick(); check(32'(busy_cnt));
        sb_addr = 5'd4; push("set_r4_cnt", 32'd2); push("r3_busy", 32'd1);
        tick(); idle(); raddr1 = 5'd3; #1;
        check(32'(busy_cnt)); check(32'(rbusy1));
        we0 = 1'b1; waddr0 = 5'd3; wdata0 = 32'h33333333;
        push("clr_r3_busy", 32'd0); push("clr_r3_cnt", 32'd1);
        tick(); idle(); #1;
        check(32'(rbusy1)); check(32'(busy_cnt));
        sb_set = 1'b1; sb_addr = 5'd4; we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h44444444;
        push("coll_cnt", 32'd1); push("coll_r4_busy", 32'd1); push("coll_r4_data", 32'h44444444);
        tick(); idle(); raddr2 = 5'd4; #1;
        check(32'(busy_cnt)); check(32'(rbusy2)); check(rdata2);
        we0 = 1'b1; waddr0 = 5'd5; wdata0 = 32'h55555555;
        push("wr_nonbusy_cnt", 32'd1);
        tick(); idle(); #1;
        check(32'(busy_cnt));

        // Same-cycle read of a register being written (r9) and busy cleared (r4)
        we0 = 1'b1; waddr0 = 5'd9; wdata0 = 32'h12345678; raddr1 = 5'd9;
        we1 = 1'b1; waddr1 = 5'd4; wdata1 = 32'h66666666; raddr2 = 5'd4; #1;
`ifdef REGFILE_BYPASS_EN
        push("byp_r9_same", 32'h12345678); push("byp_r4_busy_same", 32'd0);
`else
        push("nobyp_r9_same", 32'h0); push("nobyp_r4_busy_same", 32'd1);
`endif
        check(rdata1); check(32'(rbusy2));
        push("r9_next", 32'h12345678); push("r4_busy_next", 32'd0); push("cnt_after_clr", 32'd0);
        tick(); idle(); #1;
        check(rdata1); check(32'(rbusy2)); check(32'(busy_cnt));

        // Build busy state, then reset mid-operation (with writes/set in the reset cycle)
        for (int r = 1; r <= 4; r++) begin
            sb_set = 1'b1; sb_addr = ADDR_W'(r);
            if (r == 1) begin
                we0 = 1'b1; waddr0 = 5'd10; wdata0 = 32'hA5A5A5A5;
            end
            tick(); idle();
        end
        raddr1 = 5'd10; raddr2 = 5'd2; #1;
        push("pre_rst_cnt", 32'd4); push("pre_rst_r10", 32'hA5A5A5A5); push("pre_rst_r2_busy", 32'd1);
        check(32'(busy_cnt)); check(rdata1); check(32'(rbusy2));
        reset = 1'b1;
        we1 = 1'b1; waddr1 = 5'd11; wdata1 = 32'hBBBBBBBB; sb_set = 1'b1; sb_addr = 5'd12;
        tick(); reset = 1'b0; idle(); #1;
        push("rst2_cnt", 32'd0); push("rst2_r10", 32'h0); push("rst2_r2_busy", 32'd0);
        check(32'(busy_cnt)); check(rdata1); check(32'(rbusy2));
        raddr1 = 5'd11; raddr2 = 5'd12; #1;
        push("rst2_r11", 32'h0); push("rst2_r12_busy", 32'd0); push("rst2_r1_busy", 32'd0);
        check(rdata1); check(32'(rbusy2));
        raddr2 = 5'd1; #1;
        check(32'(rbusy2));

        n_assert++;
        assert (sb_q.size() == 0) else begin
            n_fail++;
            $error("FAIL sb_drain observed=%0d expected=0", sb_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
